// File: rtl/seven_seg_scanner_n.sv
// Multiplexed seven-segment display driver: free-running prescaler, rotating active-low anode,
// registered hex-decoded segments. Optional SCAN_BLANK_EN inserts one dark cycle at each slot start.
module seven_seg_scanner_n #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 100000,
  localparam int unsigned IDX_W   = (DIGITS > 2) ? $clog2(DIGITS) : 1,
  localparam int unsigned PW      = $clog2(PRESCALE)
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic [4*DIGITS-1:0]   values,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [DIGITS-1:0]     dp,
  output logic [DIGITS-1:0]     anode,
  output logic [6:0]            cathode,
  output logic                  dp_n,
  output logic [IDX_W-1:0]      digit_idx
);

`ifdef SCAN_BLANK_EN
  localparam bit BLANK_ON_TICK = 1'b1;
`else
  localparam bit BLANK_ON_TICK = 1'b0;
`endif

  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  logic [PW-1:0]     presc_q, presc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIGITS-1:0] anode_q, anode_d;
  logic [6:0]        cathode_q, cathode_d;
  logic              dp_n_q, dp_n_d;
  logic              tick_c;
  logic [3:0]        nibble_c;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'b1000000;
      4'h1: hex_to_seg = 7'b1111001;
      4'h2: hex_to_seg = 7'b0100100;
      4'h3: hex_to_seg = 7'b0110000;
      4'h4: hex_to_seg = 7'b0011001;
      4'h5: hex_to_seg = 7'b0010010;
      4'h6: hex_to_seg = 7'b0000010;
      4'h7: hex_to_seg = 7'b1111000;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0010000;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b0000011;
      4'hC: hex_to_seg = 7'b1000110;
      4'hD: hex_to_seg = 7'b0100001;
      4'hE: hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  // Slot timing and next digit index; outputs decode from the next index so they track it.
  always_comb begin
    presc_d   = presc_q + 1'b1;
    idx_d     = idx_q;
    anode_d   = '1;
    cathode_d = 7'h7F;
    dp_n_d    = 1'b1;
    tick_c    = (presc_q == PRESC_LAST);
    if (tick_c) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    nibble_c = values[{idx_d, 2'b00} +: 4];
    if (digit_en[idx_d] && !(BLANK_ON_TICK && tick_c)) begin
      anode_d[idx_d] = 1'b0;
      cathode_d      = hex_to_seg(nibble_c);
      dp_n_d         = ~dp[idx_d];
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      presc_q   <= '0;
      idx_q     <= '0;
      anode_q   <= ~DIGITS'(1);
      cathode_q <= 7'h7F;
      dp_n_q    <= 1'b1;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
      dp_n_q    <= dp_n_d;
    end
  end

  assign anode     = anode_q;
  assign cathode   = cathode_q;
  assign dp_n      = dp_n_q;
  assign digit_idx = idx_q;

endmodule
